// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
// Module : md_pkg
// Brief  : Shared definitions for the multiply/divide controller.
//          - md_op encodings
//          - FSM state type
//          - default latency constants
// Rev    : 1.0  initial release
// ============================================================================
package md_pkg;

    // md_op encodings, sampled together with start
    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    // Controller states
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_t;

    // Default busy-period lengths in cycles
    localparam int c_mult_cycles_def = 5;
    localparam int c_div_cycles_def  = 10;

endpackage : md_pkg
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
// Module : md_arith
// Brief  : Combinational result generator for MULT/MULTU/DIV/DIVU.
// Ports  : op      in  2   operation (md_pkg encodings)
//          a       in  32  operand A (rs: multiplicand / dividend)
//          b       in  32  operand B (rt: multiplier / divisor)
//          cur_hi  in  32  current HI, returned on divide by zero
//          cur_lo  in  32  current LO, returned on divide by zero
//          res_hi  out 32  HI result
//          res_lo  out 32  LO result
// Rev    : 1.0  initial release
// ============================================================================
module md_arith
    import md_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] cur_hi,
    input  logic [31:0] cur_lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] w_umul;
    logic [63:0] w_smul;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_mag_quot;
    logic [31:0] w_mag_rem;
    logic [31:0] w_squot;
    logic [31:0] w_srem;
    logic [31:0] w_uquot;
    logic [31:0] w_urem;
    logic        w_div0;

    // Sign-extending to 64 bits lets one unsigned multiplier produce the
    // correct two's-complement product for the signed case.
    assign w_umul = {32'd0, a} * {32'd0, b};
    assign w_smul = {{32{a[31]}}, a} * {{32{b[31]}}, b};

    // Signed divide is done on magnitudes, then signs are restored.  This
    // keeps 0x80000000 / -1 well defined: the magnitude quotient is
    // 0x80000000 and negating it wraps back to 0x80000000, remainder 0.
    assign w_a_mag    = a[31] ? (~a + 32'd1) : a;
    assign w_b_mag    = b[31] ? (~b + 32'd1) : b;
    assign w_div0     = (b == 32'd0);
    assign w_mag_quot = w_div0 ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_mag_rem  = w_div0 ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_squot    = (a[31] ^ b[31]) ? (~w_mag_quot + 32'd1) : w_mag_quot;
    assign w_srem     = a[31] ? (~w_mag_rem + 32'd1) : w_mag_rem;
    assign w_uquot    = w_div0 ? 32'd0 : (a / b);
    assign w_urem     = w_div0 ? 32'd0 : (a % b);

    always_comb begin
        res_hi = cur_hi;
        res_lo = cur_lo;
        case (op)
            MD_MULT: begin
                res_hi = w_smul[63:32];
                res_lo = w_smul[31:0];
            end
            MD_MULTU: begin
                res_hi = w_umul[63:32];
                res_lo = w_umul[31:0];
            end
            MD_DIV: begin
                if (!w_div0) begin
                    res_hi = w_srem;
                    res_lo = w_squot;
                end
            end
            MD_DIVU: begin
                if (!w_div0) begin
                    res_hi = w_urem;
                    res_lo = w_uquot;
                end
            end
            default: begin
                res_hi = cur_hi;
                res_lo = cur_lo;
            end
        endcase
    end

endmodule : md_arith
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
// Module : md_ctrl
// Brief  : Multiply/divide controller owning HI/LO. Runs MULT/MULTU/DIV/DIVU
//          over a fixed latency, services MTHI/MTLO, requests stalls.
// Ports  : clk       in  1   system clock, rising edge
//          reset     in  1   asynchronous active-low reset
//          start     in  1   E-stage MD instruction issues this cycle
//          md_op     in  2   operation, sampled with start
//          rs_val    in  32  operand A
//          rt_val    in  32  operand B
//          hi_we     in  1   MTHI write enable
//          lo_we     in  1   MTLO write enable
//          wdata     in  32  MTHI/MTLO data
//          md_use_d  in  1   D-stage instruction uses the MD unit
//          busy      out 1   operation in flight
//          stall     out 1   stall request to the hazard unit
//          hi        out 32  HI register
//          lo        out 32  LO register
// Rev    : 1.0  initial release
// ============================================================================
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = c_mult_cycles_def,
    parameter int DIV_CYCLES  = c_div_cycles_def
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);

    md_state_t            r_state;
    md_state_t            w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;
    logic [31:0]          w_hi_nxt;
    logic [31:0]          w_lo_nxt;
    logic [31:0]          r_pend_hi;
    logic [31:0]          r_pend_lo;
    logic [31:0]          w_pend_hi_nxt;
    logic [31:0]          w_pend_lo_nxt;
    logic [31:0]          w_res_hi;
    logic [31:0]          w_res_lo;

    md_arith u_arith (
        .op     (md_op),
        .a      (rs_val),
        .b      (rt_val),
        .cur_hi (r_hi),
        .cur_lo (r_lo),
        .res_hi (w_res_hi),
        .res_lo (w_res_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_hi      <= w_hi_nxt;
            r_lo      <= w_lo_nxt;
            r_pend_hi <= w_pend_hi_nxt;
            r_pend_lo <= w_pend_lo_nxt;
        end
    end

    // Result is computed at issue and held in the pend registers; the busy
    // period only models latency. HI/LO change once, at the commit edge.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hi_nxt      = r_hi;
        w_lo_nxt      = r_lo;
        w_pend_hi_nxt = r_pend_hi;
        w_pend_lo_nxt = r_pend_lo;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // An MT write on the same edge as an issue is dropped.
                    w_pend_hi_nxt = w_res_hi;
                    w_pend_lo_nxt = w_res_lo;
                    w_cnt_nxt     = (md_op == MD_DIV || md_op == MD_DIVU) ?
                                    c_cnt_w'(DIV_CYCLES) : c_cnt_w'(MULT_CYCLES);
                    w_state_nxt   = S_BUSY;
                end else begin
                    if (hi_we) w_hi_nxt = wdata;
                    if (lo_we) w_lo_nxt = wdata;
                end
            end
            S_BUSY: begin
                // start and MT writes are ignored here; hazard logic keeps
                // them from arriving.
                if (r_cnt == c_cnt_w'(1)) begin
                    w_hi_nxt    = r_pend_hi;
                    w_lo_nxt    = r_pend_lo;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign busy  = (r_state == S_BUSY);
    assign stall = md_use_d & (busy | start);
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule : md_ctrl
`default_nettype wire

// File: tb/tb_md_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_md_ctrl
// Brief  : Directed self-checking bench for md_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
module tb_md_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        md_use_d;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp;
    int n_err;

    md_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .md_use_d (md_use_d),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op and follow it to commit. With inject set, a MULT 2*3 and
    // an MTHI of 0xAA are pulsed in busy cycle 3 and must have no effect.
    task automatic do_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int ncyc, input logic use_d, input bit inject);
        int cnt;
        md_op    = op;
        rs_val   = a;
        rt_val   = b;
        md_use_d = use_d;
        start    = 1'b1;
        #1;
        chk({tag, " stall@start"}, {31'd0, stall}, {31'd0, use_d});
        step();
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        cnt   = 0;
        while (busy && cnt < 50) begin
            cnt++;
            if (inject && cnt == 3) begin
                start  = 1'b1;
                md_op  = 2'd0;
                rs_val = 32'd2;
                rt_val = 32'd3;
                hi_we  = 1'b1;
                wdata  = 32'hAA;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
            end
            #1;
            chk({tag, " stall@busy"}, {31'd0, stall}, {31'd0, use_d});
            step();
        end
        start = 1'b0;
        hi_we = 1'b0;
        chk({tag, " busy_cycles"}, cnt, ncyc);
        chk({tag, " stall@done"}, {31'd0, stall}, 32'd0);
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
        md_use_d = 1'b0;
    endtask

    initial begin
        int cnt;
        n_cmp    = 0;
        n_err    = 0;
        reset    = 1'b0;
        start    = 1'b0;
        md_op    = 2'd0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        wdata    = 32'd0;
        md_use_d = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        step();

        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);

        do_op("MULT -3*5",  2'd0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 1'b1, 1'b0);
        do_op("MULTU",      2'd1, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, 5, 1'b0, 1'b0);
        do_op("DIVU 17/5",  2'd3, 32'd17,       32'd5, 32'd2,        32'd3,        10, 1'b1, 1'b1);
        do_op("DIV -7/2",   2'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0, 1'b0);
        do_op("DIV 7/-2",   2'd2, 32'd7, 32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10, 1'b0, 1'b0);
        do_op("DIV ovf",    2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, 1'b0, 1'b0);

        // MTHI then MTLO in IDLE
        hi_we = 1'b1; wdata = 32'h11;
        step();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
        step();
        lo_we = 1'b0;
        chk("MTHI", hi, 32'h11);
        chk("MTLO", lo, 32'h22);

        do_op("DIV /0",  2'd2, 32'd9, 32'd0, 32'h11, 32'h22, 10, 1'b1, 1'b0);
        do_op("DIVU /0", 2'd3, 32'd9, 32'd0, 32'h11, 32'h22, 10, 1'b0, 1'b0);

        // Both MT enables together
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h33;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        chk("MT both hi", hi, 32'h33);
        chk("MT both lo", lo, 32'h33);

        // MTLO on the same edge as an issue is dropped
        lo_we = 1'b1; wdata = 32'h55;
        do_op("MULTU+MTLO", 2'd1, 32'd2, 32'd2, 32'd0, 32'd4, 5, 1'b0, 1'b0);

        // Asynchronous reset in busy cycle 4 of a DIV
        md_op = 2'd2; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
        step();
        start = 1'b0;
        cnt = 1;
        while (busy && cnt < 4) begin
            step();
            cnt++;
        end
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async rst busy", {31'd0, busy}, 32'd0);
        chk("async rst hi", hi, 32'd0);
        chk("async rst lo", lo, 32'd0);
        step();
        #3 reset = 1'b1;
        step();
        chk("post rst busy", {31'd0, busy}, 32'd0);
        chk("post rst lo", lo, 32'd0);
        do_op("MULT 6*7", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_md_ctrl
`default_nettype wire
